// File: rtl/uart_receiver_pkg.sv
// ----------------------------------------------------------------------------
// uart_receiver_pkg
// Shared definitions for the UART receive path. The transmitter uses the
// same configuration encodings, so one configuration word drives both ends.
//   - FSM state encodings for uart_receiver
//   - parity-mode encodings (par port)
//   - bit-period decode helpers (bd_rate port -> N = 1, 2, 4, 8 clocks)
// ----------------------------------------------------------------------------
package uart_receiver_pkg;

    // Receiver FSM states
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP1     = 3'd4;
    localparam logic [2:0] S_STOP2     = 3'd5;
    localparam logic [2:0] S_WAIT_HIGH = 3'd6;

    // Parity modes; 2'b11 also means no parity
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_XOR  = 2'b01;
    localparam logic [1:0] PAR_XNOR = 2'b10;

    // bd_rate codes: bit period N = 1 << bd_rate
    localparam logic [1:0] BD_1 = 2'b00;
    localparam logic [1:0] BD_2 = 2'b01;
    localparam logic [1:0] BD_4 = 2'b10;
    localparam logic [1:0] BD_8 = 2'b11;

    // Counter reload for one full bit period (N-1).
    function automatic logic [2:0] period_m1(input logic [1:0] rate);
        case (rate)
            BD_1:    return 3'd0;
            BD_2:    return 3'd1;
            BD_4:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    // Counter load at start detection so the start bit is sampled N/2
    // cycles after its falling edge (START is entered one cycle after the
    // edge, hence N/2-1). Not used at N=1.
    function automatic logic [2:0] half_m1(input logic [1:0] rate);
        case (rate)
            BD_4:    return 3'd1;
            BD_8:    return 3'd3;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic parity_on(input logic [1:0] par);
        return (par == PAR_XOR) || (par == PAR_XNOR);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial line.
//   clk  in  system clock
//   rst  in  asynchronous active-low reset
//   din  in  raw serial line (idles high)
//   rx   out synchronized line, 2 cycles behind din
// ----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rx
);

    logic meta_q;
    logic sync_q;

    // NOTE: both flops reset to 1 (the line's idle level) so leaving reset
    // never looks like a start bit to the receiver.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make this a true two-stage
            // pipeline; blocking ones would collapse it into a single flop.
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    assign rx = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// ----------------------------------------------------------------------------
// uart_receiver
// Serial-to-parallel UART receiver: start bit, 7/8 data bits LSB-first,
// optional XOR/XNOR parity, 1 or 2 stop bits, bit period of 1/2/4/8 clocks.
//   clk         in  system clock
//   rst         in  asynchronous active-low reset
//   din         in  serial line, idles high, asynchronous to clk
//   dnum        in  1 = 8 data bits, 0 = 7 data bits
//   snum        in  1 = 2 stop bits, 0 = 1 stop bit
//   par         in  00/11 none, 01 XOR parity, 10 XNOR parity
//   bd_rate     in  bit period N = 1 << bd_rate clocks
//   data_out    out last received word (bit 7 = 0 in 7-bit mode)
//   valid       out one-cycle strobe when data_out / error flags update
//   parity_err  out parity mismatch on the flagged word
//   frame_err   out a stop bit was sampled 0 on the flagged word
//   busy        out high from start detection until back in IDLE
// ----------------------------------------------------------------------------
module uart_receiver
    import uart_receiver_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       dnum,
    input  logic       snum,
    input  logic [1:0] par,
    input  logic [1:0] bd_rate,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    logic rx;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .din (din),
        .rx  (rx)
    );

    logic [2:0] state_q, state_d;
    logic [2:0] tick_q, tick_d;
    logic [3:0] bits_q, bits_d;
    logic [7:0] shift_q, shift_d;
    logic       cfg_dnum_q, cfg_dnum_d;
    logic       cfg_snum_q, cfg_snum_d;
    logic [1:0] cfg_par_q, cfg_par_d;
    logic [1:0] cfg_rate_q, cfg_rate_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       parity_err_q, parity_err_d;
    logic       frame_err_q, frame_err_d;

    logic       tick_done;
    logic       finish;
    logic       frame_bad;
    logic [7:0] word;
    logic       par_exp;

    assign tick_done = (tick_q == 3'd0);
    // Bits enter at bit 7, so a 7-bit word ends up in shift_q[7:1].
    assign word      = cfg_dnum_q ? shift_q : {1'b0, shift_q[7:1]};
    assign par_exp   = (cfg_par_q == PAR_XNOR) ? ~^word : ^word;
    assign frame_bad = ferr_q | ~rx;

    always_comb begin
        // NOTE: every *_d defaults to its *_q (valid to 0) before the case,
        // so no path leaves a signal unassigned and no latch is inferred.
        state_d      = state_q;
        tick_d       = tick_q;
        bits_d       = bits_q;
        shift_d      = shift_q;
        cfg_dnum_d   = cfg_dnum_q;
        cfg_snum_d   = cfg_snum_q;
        cfg_par_d    = cfg_par_q;
        cfg_rate_d   = cfg_rate_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        finish       = 1'b0;

        // The tick counter runs down on its own; each state reloads it on expiry.
        if (!tick_done) begin
            tick_d = tick_q - 3'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx) begin
                    cfg_dnum_d = dnum;
                    cfg_snum_d = snum;
                    cfg_par_d  = par;
                    cfg_rate_d = bd_rate;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    if (bd_rate == BD_1) begin
                        // At N=1 this detection cycle is already the start-bit
                        // midpoint; the next cycle holds data bit 0.
                        state_d = S_DATA;
                        tick_d  = 3'd0;
                        bits_d  = dnum ? 4'd8 : 4'd7;
                    end else begin
                        state_d = S_START;
                        tick_d  = half_m1(bd_rate);
                    end
                end
            end
            S_START: begin
                if (tick_done) begin
                    if (!rx) begin
                        state_d = S_DATA;
                        tick_d  = period_m1(cfg_rate_q);
                        bits_d  = cfg_dnum_q ? 4'd8 : 4'd7;
                    end else begin
                        state_d = S_IDLE;   // glitch, not a start bit
                    end
                end
            end
            S_DATA: begin
                if (tick_done) begin
                    shift_d = {rx, shift_q[7:1]};
                    bits_d  = bits_q - 4'd1;
                    tick_d  = period_m1(cfg_rate_q);
                    if (bits_q == 4'd1) begin
                        state_d = parity_on(cfg_par_q) ? S_PARITY : S_STOP1;
                    end
                end
            end
            S_PARITY: begin
                if (tick_done) begin
                    perr_d  = (rx != par_exp);
                    tick_d  = period_m1(cfg_rate_q);
                    state_d = S_STOP1;
                end
            end
            S_STOP1: begin
                if (tick_done) begin
                    if (cfg_snum_q) begin
                        ferr_d  = frame_bad;
                        tick_d  = period_m1(cfg_rate_q);
                        state_d = S_STOP2;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            S_STOP2: begin
                if (tick_done) begin
                    finish = 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (rx) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Last stop sample: publish the word and leave in the same step, so
        // IDLE is live on the cycle valid is high (back-to-back at N=1).
        if (finish) begin
            valid_d      = 1'b1;
            data_d       = word;
            parity_err_d = perr_q;
            frame_err_d  = frame_bad;
            ferr_d       = frame_bad;
            state_d      = frame_bad ? S_WAIT_HIGH : S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            tick_q       <= 3'd0;
            bits_q       <= 4'd0;
            shift_q      <= 8'd0;
            cfg_dnum_q   <= 1'b0;
            cfg_snum_q   <= 1'b0;
            cfg_par_q    <= PAR_NONE;
            cfg_rate_q   <= BD_1;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            data_q       <= 8'd0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bits_q       <= bits_d;
            shift_q      <= shift_d;
            cfg_dnum_q   <= cfg_dnum_d;
            cfg_snum_q   <= cfg_snum_d;
            cfg_par_q    <= cfg_par_d;
            cfg_rate_q   <= cfg_rate_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// ----------------------------------------------------------------------------
// tb_uart_receiver
// Drives serial frames into uart_receiver. For each frame the bench works out,
// from the frame format alone, the word, the error flags and the exact cycle
// valid must pulse (2-cycle synchronizer + midpoint of the last stop bit + 1),
// and a per-cycle compare process checks valid and the held outputs.
// ----------------------------------------------------------------------------
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b1;
    logic       dnum = 1'b1;
    logic       snum = 1'b0;
    logic [1:0] par = 2'b00;
    logic [1:0] bd_rate = 2'b00;
    logic [7:0] data_out;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    uart_receiver dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .dnum       (dnum),
        .snum       (snum),
        .par        (par),
        .bd_rate    (bd_rate),
        .data_out   (data_out),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] held_data = 8'd0;
    logic       held_perr = 1'b0;
    logic       held_ferr = 1'b0;
    bit         checking = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Per-cycle compare against the model's expectation queue.
    exp_t cur;
    always @(negedge clk) begin
        if (checking) begin
            if (!rst) check("busy_in_reset", busy, 0);
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                cur = exp_q.pop_front();
                check("valid_strobe", valid, 1);
                held_data = cur.data;
                held_perr = cur.perr;
                held_ferr = cur.ferr;
            end else begin
                check("valid_quiet", valid, 0);
            end
            check("data_out", data_out, held_data);
            check("parity_err", parity_err, held_perr);
            check("frame_err", frame_err, held_ferr);
        end
    end

    function automatic int period(input logic [1:0] rate);
        return 1 << rate;
    endfunction

    // Serial bit sequence of one frame, in transmission order.
    // bad_stop: 0 none, 1 force stop bit 1 low, 2 force stop bit 2 low.
    task automatic build_frame(input logic [7:0] data, input logic d8, input logic [1:0] p,
                               input logic s2, input logic flip_par, input int bad_stop,
                               output logic [15:0] bits, output int len);
        int         n;
        logic [7:0] w;
        bits = '0;
        n    = d8 ? 8 : 7;
        w    = d8 ? data : {1'b0, data[6:0]};
        bits[0] = 1'b0;
        for (int i = 0; i < n; i++) bits[1 + i] = w[i];
        len = 1 + n;
        if (p == 2'b01 || p == 2'b10) begin
            bits[len] = ((p == 2'b01) ? (^w) : ~(^w)) ^ flip_par;
            len++;
        end
        bits[len] = (bad_stop != 1);
        len++;
        if (s2) begin
            bits[len] = (bad_stop != 2);
            len++;
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int k);
        din = 1'b1;
        step(k);
    endtask

    task automatic drive_bits(input logic [15:0] bits, input int count, input int n, input bit scramble);
        for (int i = 0; i < count; i++) begin
            din = bits[i];
            if (scramble && i >= 3) {dnum, snum, par, bd_rate} = 6'($urandom);
            step(n);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic d8, input logic [1:0] p,
                              input logic s2, input logic [1:0] rate, input logic flip_par,
                              input int bad_stop, input bit scramble, output int vcyc);
        logic [15:0] bits;
        int          len;
        int          n;
        exp_t        e;
        build_frame(data, d8, p, s2, flip_par, bad_stop, bits, len);
        n       = period(rate);
        dnum    = d8;
        snum    = s2;
        par     = p;
        bd_rate = rate;
        // rx sees the start bit 2 cycles later; last bit sampled at its midpoint.
        e.cyc  = cyc + 2 + (len - 1) * n + n / 2 + 1;
        e.data = d8 ? data : {1'b0, data[6:0]};
        e.perr = (p == 2'b01 || p == 2'b10) && flip_par;
        e.ferr = (bad_stop != 0);
        exp_q.push_back(e);
        vcyc = e.cyc;
        drive_bits(bits, len, n, scramble);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && exp_q.size() > 0; i++) step(1);
        if (exp_q.size() > 0) begin
            check("valid_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    logic [15:0] fbits;
    int          flen;
    int          d0;
    int          vc;
    logic [7:0]  rd;
    logic        rd8, rs2, rfp;
    logic [1:0]  rp, rr;
    int          rbs;
    int          gap;

    initial begin
        rst = 1'b0;
        din = 1'b1;
        step(3);
        checking = 1'b1;
        check("reset_data_out", data_out, 0);
        check("reset_valid", valid, 0);
        check("reset_parity_err", parity_err, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);
        rst = 1'b1;
        idle(4);

        // Pin the frame model with hand-worked sequences.
        build_frame(8'h35, 1'b0, 2'b01, 1'b0, 1'b0, 0, fbits, flen);
        check("model_frame_35_bits", fbits, 16'h026A);
        check("model_frame_35_len", flen, 10);
        build_frame(8'h3C, 1'b1, 2'b10, 1'b1, 1'b0, 0, fbits, flen);
        check("model_xnor_bit_3c", fbits[9], 1);
        check("model_frame_3c_len", flen, 12);

        // 0xA5, 8N1, N=1
        d0 = cyc;
        send_frame(8'hA5, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 0, 1'b0, vc);
        check("model_latency_a5", vc - d0, 12);
        idle(4);
        wait_drain();
        check("a5_data", data_out, 8'hA5);
        check("a5_perr", parity_err, 0);
        check("a5_ferr", frame_err, 0);

        // 0x35, 7 bits, XOR parity, N=2: good then flipped parity
        send_frame(8'h35, 1'b0, 2'b01, 1'b0, 2'b01, 1'b0, 0, 1'b0, vc);
        idle(4);
        wait_drain();
        check("x35_data", data_out, 8'h35);
        check("x35_perr_good", parity_err, 0);
        send_frame(8'h35, 1'b0, 2'b01, 1'b0, 2'b01, 1'b1, 0, 1'b0, vc);
        idle(4);
        wait_drain();
        check("x35_data_flip", data_out, 8'h35);
        check("x35_perr_flip", parity_err, 1);

        // 0x3C, XNOR parity, 2 stop bits, N=8
        d0 = cyc;
        send_frame(8'h3C, 1'b1, 2'b10, 1'b1, 2'b11, 1'b0, 0, 1'b0, vc);
        check("model_latency_3c", vc - d0, 95);
        idle(8);
        wait_drain();
        check("x3c_data", data_out, 8'h3C);
        check("x3c_perr", parity_err, 0);
        check("x3c_ferr", frame_err, 0);

        // Stop bit low, then break held for 40 cycles (N=2)
        send_frame(8'h55, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 1, 1'b0, vc);
        din = 1'b0;
        step(40);
        check("break_busy_held", busy, 1);
        check("break_ferr", frame_err, 1);
        idle(6);
        check("break_busy_released", busy, 0);
        check("break_data", data_out, 8'h55);
        wait_drain();

        // One-cycle glitch at N=4: no frame
        bd_rate = 2'b10;
        din = 1'b0;
        step(1);
        idle(12);
        check("glitch_busy", busy, 0);

        // Three back-to-back frames at N=1
        send_frame(8'h01, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 0, 1'b0, vc);
        send_frame(8'hFE, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 0, 1'b0, vc);
        send_frame(8'h7E, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 0, 1'b0, vc);
        idle(4);
        wait_drain();
        check("b2b_last_data", data_out, 8'h7E);

        // Reset in the middle of DATA (N=4), then a clean frame
        dnum = 1'b1; snum = 1'b0; par = 2'b00; bd_rate = 2'b10;
        build_frame(8'hC3, 1'b1, 2'b00, 1'b0, 1'b0, 0, fbits, flen);
        drive_bits(fbits, 4, 4, 1'b0);
        check("mid_frame_busy", busy, 1);
        rst = 1'b0;
        din = 1'b1;
        exp_q.delete();
        held_data = 8'd0;
        held_perr = 1'b0;
        held_ferr = 1'b0;
        step(3);
        check("rst_mid_data_out", data_out, 0);
        check("rst_mid_busy", busy, 0);
        rst = 1'b1;
        idle(4);
        send_frame(8'hC3, 1'b1, 2'b00, 1'b0, 2'b10, 1'b0, 0, 1'b0, vc);
        idle(4);
        wait_drain();
        check("after_rst_data", data_out, 8'hC3);

        // Randomized frames; config ports are scrambled mid-frame.
        for (int k = 0; k < 40; k++) begin
            rd  = 8'($urandom);
            rd8 = 1'($urandom_range(0, 1));
            rp  = 2'($urandom);
            rr  = 2'($urandom);
            rs2 = 1'($urandom_range(0, 1));
            rfp = ($urandom_range(0, 3) == 0);
            rbs = 0;
            if ($urandom_range(0, 7) == 0) rbs = rs2 ? int'($urandom_range(1, 2)) : 1;
            send_frame(rd, rd8, rp, rs2, rr, rfp, rbs, 1'b1, vc);
            gap = (rbs != 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 2));
            if (gap > 0) idle(gap * period(rr));
        end
        idle(4);
        wait_drain();
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel receive end of the team's UART link, the counterpart of the UART transmitter. It recovers frames from a single serial line: start bit 0, 7 or 8 data bits LSB-first, optional parity, then 1 or 2 stop bits. It presents each received word with a one-cycle valid strobe plus parity and framing error flags. It uses the same `dnum`/`snum`/`par`/`bd_rate` configuration encoding as the transmitter, so one configuration word drives both ends.

## Interface
- No parameters; all configuration arrives on ports.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `din`  in  1  serial line; idles high; asynchronous to `clk`.
- `dnum`  in  1  1 = 8 data bits, 0 = 7 data bits.
- `snum`  in  1  1 = 2 stop bits, 0 = 1 stop bit.
- `par`  in  2  00/11 = no parity; 01 = parity bit is XOR of the data bits; 10 = parity bit is XNOR of the data bits.
- `bd_rate`  in  2  bit period N clocks: 00→1, 01→2, 10→4, 11→8.
- `data_out`  out  8  last received word; bit 7 is 0 in 7-bit mode.
- `valid`  out  1  one-cycle strobe when `data_out`/error flags update.
- `parity_err`  out  1  parity mismatch on the word flagged by `valid`.
- `frame_err`  out  1  a stop bit was sampled 0 on the word flagged by `valid`.
- `busy`  out  1  high from start detection until return to IDLE.

## Operation
- `din` passes through a 2-flop synchronizer, and both flops reset to 1. All logic uses the synchronized value `rx`.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
- IDLE: when `rx`=0, latch `dnum`/`snum`/`par`/`bd_rate` into internal config registers. Config changes mid-frame have no effect. Load the tick counter with N/2, then go to START.
- START: when the counter reaches 0, check `rx`.
  - If `rx`=0, reload the counter with N−1 and go to DATA.
  - If `rx`=1, treat it as a false start and return to IDLE with no `valid`.
  - For N=1 the detection cycle itself is the start sample, so START lasts 1 cycle with `rx`=0 already confirmed.
- DATA: sample `rx` each time the counter expires and reload with N−1. Shift the sample into bit 7 of the shift register (LSB-first). The bit counter counts down from 8 or 7.
  - After the last bit, go to PARITY if parity is enabled, otherwise go to STOP1.
  - In 7-bit mode, `data_out` = {1'b0, bits[6:0]}.
- PARITY: sample one bit. The expected value is XOR (par=01) or XNOR (par=10) of the 7 or 8 received data bits. A mismatch sets the internal parity-error flag.
- STOP1: sample one bit; 0 sets the internal framing flag. Go to STOP2 if `snum`=1, otherwise finish.
- STOP2: sample one bit; 0 sets the framing flag. Then finish.
- Finish: on the next cycle, register `data_out`, `parity_err` and `frame_err`, and pulse `valid` for one cycle.
  - If the framing flag is set, go to WAIT_HIGH; otherwise go to IDLE.
- WAIT_HIGH: stay until `rx`=1, then go to IDLE. This prevents a break condition (line held low) from retriggering frames.
- `data_out`, `parity_err` and `frame_err` hold their value until the next `valid`.

## Timing
- Reset values: `data_out`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0; FSM in IDLE; synchronizer flops = 1.
- Synchronizer latency is 2 cycles from `din` to `rx`.
- Each bit is sampled at its midpoint: N/2 cycles after the start edge, then every N cycles.
- `valid` rises exactly 1 cycle after the final stop-bit sample.
- At N=1, frames may arrive back-to-back: a start bit immediately after the last stop bit is detected in the cycle IDLE is re-entered. The FSM returns to IDLE in the same cycle `valid` is registered, so no frame is lost.
- Reset asserted mid-frame aborts the frame immediately: no `valid`, all outputs return to their reset values.

## Structure
- A shared package holds:
  - state encodings;
  - `bd_rate`→N decode constants;
  - `par` encoding constants (PAR_NONE, PAR_XOR, PAR_XNOR), shared with the transmitter.
- One natural sub-module, `uart_rx_sync`: the 2-flop synchronizer with set-to-1 reset.
- Counters, shift register and FSM stay in `uart_receiver`.

## Test plan
- Config `bd_rate`=00, `dnum`=1, `par`=00, `snum`=0; serial frame for 0xA5 → `valid` pulses once, `data_out`=0xA5, both error flags 0.
- Config `dnum`=0, `par`=01; frame for 0x35 with a correct parity bit (XOR of [6:0] = 0) → `data_out`=0x35, `parity_err`=0. Same frame with the parity bit flipped → `parity_err`=1, `data_out`=0x35.
- Config `par`=10, `snum`=1, `bd_rate`=11 (N=8); 0x3C framed with XNOR parity and 2 stop bits → `data_out`=0x3C, no errors; `valid` exactly 1 cycle after the second stop-bit midpoint.
- 1-stop-bit frame with the stop bit forced to 0, line then held low for 40 cycles → one `valid` with `frame_err`=1, no further `valid` until the line returns high.
- Glitch: `din` low for 1 cycle at `bd_rate`=10 (N=4) → no `valid`, FSM back in IDLE. Separately, three back-to-back frames at N=1 → three `valid` pulses with the correct data.
- Assert `rst` low in the middle of DATA → all outputs return to 0, no `valid`. The next full frame after release is received correctly.
